// File: rtl/voice_sequencer.sv
// Sample-rate scheduler for the tt6581 synth core: divides clk_i into sample ticks and
// time-multiplexes the shared voice datapath, then the filter, then the output latch.
module voice_sequencer #(
  parameter int CLK_DIV    = 1000,
  parameter int NUM_VOICES = 3,
  parameter int VSEL_W     = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              voice_done_i,
  input  logic              filt_done_i,
  input  logic              ovr_clr_i,
  output logic              sample_tick_o,
  output logic [VSEL_W-1:0] voice_sel_o,
  output logic              voice_start_o,
  output logic              accum_clr_o,
  output logic              accum_en_o,
  output logic              filt_start_o,
  output logic              out_latch_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int                CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [VSEL_W-1:0] SEL_LAST = VSEL_W'(NUM_VOICES - 1);

  // IDLE wait tick | VREQ voice start | VWAIT voice done | FREQ filter start | FWAIT filter done | LATCH load output
  typedef enum logic [2:0] {
    S_IDLE, S_VREQ, S_VWAIT, S_FREQ, S_FWAIT, S_LATCH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [VSEL_W-1:0] sel_q, sel_d;
  logic              ovr_q, ovr_d;

  // Tick is registered from the next count so it is high exactly while cnt_q == CLK_DIV-1.
  always_comb begin
    cnt_d = '0;
    if (enable_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    tick_d = enable_i && (cnt_d == CNT_LAST);
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    voice_start_o = 1'b0;
    accum_clr_o   = 1'b0;
    accum_en_o    = 1'b0;
    filt_start_o  = 1'b0;
    out_latch_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_q) begin
          state_d = S_VREQ;
          sel_d   = '0;
        end
      end
      S_VREQ: begin
        voice_start_o = 1'b1;
        accum_clr_o   = (sel_q == '0);
        state_d       = S_VWAIT;
      end
      S_VWAIT: begin
        accum_en_o = voice_done_i;
        if (voice_done_i) begin
          if (sel_q == SEL_LAST) begin
            state_d = S_FREQ;
          end else begin
            sel_d   = sel_q + VSEL_W'(1);
            state_d = S_VREQ;
          end
        end
      end
      S_FREQ: begin
        filt_start_o = 1'b1;
        state_d      = S_FWAIT;
      end
      S_FWAIT: begin
        if (filt_done_i) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        out_latch_o = 1'b1;
        sel_d       = '0;
        state_d     = S_IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A tick landing on a busy sequencer is dropped; the sticky flag records it and beats a clear.
  always_comb begin
    ovr_d = ovr_q;
    if (tick_q && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      sel_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      sel_q   <= sel_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_tick_o = tick_q;
  assign voice_sel_o   = sel_q;
  assign busy_o        = (state_q != S_IDLE);
  assign overrun_o     = ovr_q;

endmodule
